// File: rtl/alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_ctrl
// Brief    : RV32 execute-stage ALU sequencer; single-cycle ops plus serial
//            one-bit-per-cycle shifts, valid/ready on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq_ctrl #(
    parameter int XLEN        = 32,
    parameter int CODE_WIDTH  = 10,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CODE_WIDTH-1:0] in_code,
    input  logic [XLEN-1:0]       in_a,
    input  logic [XLEN-1:0]       in_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_result,
    output logic                  out_err,
    output logic                  busy
);

    localparam int c_op_add  = 0;
    localparam int c_op_sub  = 1;
    localparam int c_op_xor  = 2;
    localparam int c_op_or   = 3;
    localparam int c_op_and  = 4;
    localparam int c_op_sll  = 5;
    localparam int c_op_srl  = 6;
    localparam int c_op_sra  = 7;
    localparam int c_op_slt  = 8;
    localparam int c_op_sltu = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                 r_state;
    logic [SHAMT_WIDTH-1:0] r_cnt;
    logic [XLEN-1:0]        r_result;
    logic                   r_err;
    logic                   r_sh_left;
    logic                   r_sh_arith;

    logic                   w_onehot;
    logic                   w_is_shift;
    logic [SHAMT_WIDTH-1:0] w_shamt;
    logic [XLEN-1:0]        w_alu;
    logic [XLEN-1:0]        w_shifted;

    assign in_ready   = (r_state == IDLE) && !flush;
    assign out_valid  = (r_state == DONE);
    assign busy       = (r_state != IDLE);
    assign out_result = r_result;
    assign out_err    = r_err;

    assign w_onehot   = (in_code != '0) && ((in_code & (in_code - 1'b1)) == '0);
    assign w_is_shift = in_code[c_op_sll] | in_code[c_op_srl] | in_code[c_op_sra];
    assign w_shamt    = in_b[SHAMT_WIDTH-1:0];

    // Only meaningful when in_code is one-hot; the accept logic guarantees that.
    always_comb begin
        w_alu = '0;
        if (in_code[c_op_add])  w_alu = in_a + in_b;
        if (in_code[c_op_sub])  w_alu = in_a - in_b;
        if (in_code[c_op_xor])  w_alu = in_a ^ in_b;
        if (in_code[c_op_or])   w_alu = in_a | in_b;
        if (in_code[c_op_and])  w_alu = in_a & in_b;
        if (in_code[c_op_slt])  w_alu = {{(XLEN-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
        if (in_code[c_op_sltu]) w_alu = {{(XLEN-1){1'b0}}, (in_a < in_b)};
    end

    always_comb begin
        if (r_sh_left)
            w_shifted = {r_result[XLEN-2:0], 1'b0};
        else
            w_shifted = {(r_sh_arith & r_result[XLEN-1]), r_result[XLEN-1:1]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_result   <= '0;
            r_err      <= 1'b0;
            r_sh_left  <= 1'b0;
            r_sh_arith <= 1'b0;
        end else if (flush) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_sh_left  <= in_code[c_op_sll];
                        r_sh_arith <= in_code[c_op_sra];
                        if (!w_onehot) begin
                            r_state  <= DONE;
                            r_result <= '0;
                            r_err    <= 1'b1;
                        end else if (w_is_shift) begin
                            r_result <= in_a;
                            r_err    <= 1'b0;
                            r_cnt    <= w_shamt;
                            r_state  <= (w_shamt == '0) ? DONE : SHIFT;
                        end else begin
                            r_state  <= DONE;
                            r_result <= w_alu;
                            r_err    <= 1'b0;
                        end
                    end
                end
                SHIFT: begin
                    r_result <= w_shifted;
                    r_cnt    <= r_cnt - 1'b1;
                    if (r_cnt == SHAMT_WIDTH'(1))
                        r_state <= DONE;
                end
                DONE: begin
                    if (out_ready)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Execute-stage sequencer for the RV32 integer ALU.
- Accepts one decoded operation per handshake: a 10-bit one-hot ALU code from the ALU decode unit plus two operands.
- Single-cycle ops complete in one cycle. Shifts run serially, one bit position per cycle, to share a 1-bit shifter.
- Results leave on a valid/ready handshake towards writeback. Sits between decode and the register-file write port.

Parameters:
- XLEN, 32, operand/result width.
- CODE_WIDTH, 10, ALU code width; bit index = op: 0 add, 1 sub, 2 xor, 3 or, 4 and, 5 sll, 6 srl, 7 sra, 8 slt, 9 sltu.
- SHAMT_WIDTH, 5, shift-amount bits taken from in_b[SHAMT_WIDTH-1:0].

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  synchronous abort of any in-flight op.
- in_valid  in  1  op request valid.
- in_ready  out  1  controller can accept an op.
- in_code  in  CODE_WIDTH  one-hot ALU code.
- in_a  in  XLEN  operand A (rs1).
- in_b  in  XLEN  operand B (rs2 or immediate).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_result  out  XLEN  result.
- out_err  out  1  in_code was not exactly one-hot.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Clock/reset: one clock; reset is synchronous and active-low (rst_n sampled on clk rising edge).
- Reset (rst_n=0 at an edge, including mid-operation): state=IDLE, shift counter=0, result register=0, err=0.
  - Resulting outputs: in_ready=1, out_valid=0, out_result=0, out_err=0, busy=0.
  - Any in-flight op is dropped.
- States: IDLE, SHIFT, DONE.
- in_ready = (state==IDLE) && !flush. out_valid = (state==DONE). busy = (state!=IDLE).
- Accept: in_valid && in_ready at an edge latches in_code, in_a, in_b.
- Decision at accept:
  - Popcount(in_code)!=1 -> DONE, result=0, err=1.
  - Code is add/sub/xor/or/and/slt/sltu -> DONE, result computed that edge, err=0.
  - Code is sll/srl/sra with shamt=in_b[4:0]:
    - shamt==0 -> DONE, result=in_a.
    - Otherwise -> SHIFT, result=in_a, counter=shamt.
- SHIFT, each edge: result shifted by one bit and counter decremented.
  - sll: zero fill in LSB.
  - srl: zero fill in MSB.
  - sra: replicate result[XLEN-1].
  - Counter reaching 0 on this edge -> DONE.
- Latency (accept edge to out_valid high):
  - Non-shift and error ops: 1 cycle.
  - Shift ops: shamt+1 cycles; shamt=0 gives 1.
- DONE: out_result/out_err held stable while out_valid && !out_ready. out_valid && out_ready at an edge -> IDLE.
- No accept is possible in DONE, so back-to-back throughput is one op per latency+1 cycles.
- Arithmetic (all modulo 2^XLEN):
  - add/sub wrap, no overflow flag.
  - slt: signed compare, result 32'h1 or 32'h0.
  - sltu: unsigned compare, same result encoding.
  - Upper bits of in_b are ignored for shifts.
- flush=1 at an edge (rst_n=1): state -> IDLE from any state, result dropped, out_valid=0 next cycle.
  - in_ready is forced 0 during flush, so no accept occurs that cycle.
  - Priority: rst_n, then flush, then normal operation.
- in_valid while busy: ignored (in_ready=0). The requester must hold its inputs until accepted.

Test Plan:
- Reset, then add: rst_n low 2 cycles, check in_ready=1, out_valid=0, out_result=0. Then in_code=10'b0000000001, a=32'hFFFFFFFF, b=1 -> out_valid one cycle after accept, result=32'h0, err=0.
- slt vs sltu: a=32'hFFFFFFFF, b=1. slt (bit 8) -> 32'h1. sltu (bit 9) -> 32'h0. sub (bit 1) with a=0, b=1 -> 32'hFFFFFFFF.
- Serial shifts, a=32'h80000000:
  - sra, b=4 -> busy for 4 SHIFT cycles, out_valid 5 cycles after accept, result=32'hF8000000.
  - srl, b=4 -> 32'h08000000.
  - sll, a=1, b=31 -> 32'h80000000 after 32 cycles.
  - sll, b=32'h20 (shamt 0) -> result=a after 1 cycle.
- Invalid code: in_code=0, then 10'b0000000011 -> out_err=1, out_result=0, latency 1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid, out_result, out_err stable, in_ready=0. A new in_valid during this time is not accepted. Raise out_ready -> IDLE next cycle.
- Abort: flush at SHIFT cycle 2 of sra shamt=10 -> IDLE next cycle, no out_valid. rst_n low mid-SHIFT -> same, with all outputs at reset values. The next op then completes correctly.
